// File: rtl/qrs_pkg.sv
// Shared types and constants for the QRS boundary-refinement sequencer.
package qrs_pkg;

    localparam int CNT1_W = 4;
    localparam int CNT2_W = 9;

    // Refinement commit point, also decoded by the refinement datapath.
    localparam logic [CNT1_W-1:0] REF_C1 = 4'd2;
    localparam logic [CNT2_W-1:0] REF_C2 = 9'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QFILL = 2'd1,
        ST_SFILL = 2'd2,
        ST_ALIGN = 2'd3
    } qrs_state_e;

endpackage

// File: rtl/qrs_tick_counter.sv
// Two-level sample counter: count1 is the decimation phase, count2 the decimated tick index.
module qrs_tick_counter
    import qrs_pkg::*;
#(
    parameter int DECIM = 8
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              inc,
    input  logic              clr,
    output logic [CNT1_W-1:0] count1,
    output logic [CNT2_W-1:0] count2,
    output logic              wrap
);

    localparam logic [CNT1_W-1:0] LAST_C1 = CNT1_W'(DECIM - 1);

    // High when the next increment wraps count1 and advances count2.
    assign wrap = (count1 == LAST_C1);

    // Prescaler: clear has priority, otherwise advance on each counted sample.
    always_ff @(posedge clk or negedge nReset) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!nReset) begin
            count1 <= '0;
            count2 <= '0;
        end else if (clr) begin
            count1 <= '0;
            count2 <= '0;
        end else if (inc) begin
            if (wrap) begin
                count1 <= '0;
                count2 <= count2 + 1'b1;
            end else begin
                count1 <= count1 + 1'b1;
            end
        end
    end

endmodule

// File: rtl/qrs_refine_sequencer.sv
// Sequences Q-window fill, S-window fill and the refinement commit for one detected beat.
module qrs_refine_sequencer
    import qrs_pkg::*;
#(
    parameter int DECIM    = 8,
    parameter int QWIN_LEN = 32,
    parameter int SWIN_LEN = 48
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              sample_valid,
    input  logic              r_peak,
    input  logic              abort,
    input  logic              clr_ovr,
    output logic [CNT1_W-1:0] count1,
    output logic [CNT2_W-1:0] count2,
    output logic              qwindow1_full,
    output logic              swindow1_full,
    output logic              refine_strobe,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [CNT2_W-1:0] Q_LAST = CNT2_W'(QWIN_LEN - 1);
    localparam logic [CNT2_W-1:0] S_LAST = CNT2_W'(SWIN_LEN - 1);

    qrs_state_e state_q, state_d;
    logic       q_full_q, q_full_d;
    logic       s_full_q, s_full_d;
    logic       done_q, done_d;
    logic       overrun_q;
    logic       cnt_inc, cnt_clr, at_wrap, tick_wrap, at_commit;

    qrs_tick_counter #(.DECIM(DECIM)) u_tick (
        .clk    (clk),
        .nReset (nReset),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .count1 (count1),
        .count2 (count2),
        .wrap   (at_wrap)
    );

    assign tick_wrap = sample_valid && at_wrap;
    // Commit is a decode of registered state/counts; the sample arriving in that cycle is dropped.
    assign at_commit = (state_q == ST_ALIGN) && (count1 == REF_C1) && (count2 == REF_C2);
    assign cnt_inc   = sample_valid && !at_commit;

    // Next-state, window-flag and counter-clear decode.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d       = state_q;
        q_full_d      = q_full_q;
        s_full_d      = s_full_q;
        done_d        = 1'b0;
        cnt_clr       = 1'b0;
        refine_strobe = 1'b0;
        if (abort) begin
            state_d  = ST_IDLE;
            q_full_d = 1'b0;
            s_full_d = 1'b0;
            cnt_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    q_full_d = 1'b0;
                    s_full_d = 1'b0;
                    cnt_clr  = 1'b1;
                    if (r_peak) state_d = ST_QFILL;
                end
                ST_QFILL: begin
                    if (tick_wrap && count2 == Q_LAST) begin
                        q_full_d = 1'b1;
                        cnt_clr  = 1'b1;
                        state_d  = ST_SFILL;
                    end
                end
                ST_SFILL: begin
                    if (tick_wrap && count2 == S_LAST) begin
                        s_full_d = 1'b1;
                        cnt_clr  = 1'b1;
                        state_d  = ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (at_commit) begin
                        refine_strobe = 1'b1;
                        done_d        = 1'b1;
                        q_full_d      = 1'b0;
                        s_full_d      = 1'b0;
                        cnt_clr       = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // State, window flags and the one-clock done pulse.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= ST_IDLE;
            q_full_q <= 1'b0;
            s_full_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_full_q <= q_full_d;
            s_full_q <= s_full_d;
            done_q   <= done_d;
        end
    end

    // Sticky overrun: an R-peak while busy sets it, and setting wins over clr_ovr.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)                     overrun_q <= 1'b0;
        else if (r_peak && busy)         overrun_q <= 1'b1;
        else if (clr_ovr)                overrun_q <= 1'b0;
    end

    assign busy          = (state_q != ST_IDLE);
    assign qwindow1_full = q_full_q;
    assign swindow1_full = s_full_q;
    assign done          = done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_qrs_refine_sequencer.sv
// Directed self-checking bench for qrs_refine_sequencer with DECIM=8, QWIN_LEN=32, SWIN_LEN=48.
module tb_qrs_refine_sequencer;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       sample_valid = 1'b0;
    logic       r_peak = 1'b0;
    logic       abort = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [3:0] count1;
    logic [8:0] count2;
    logic       qwindow1_full, swindow1_full, refine_strobe, busy, done, overrun;

    int n_checks = 0;
    int n_pass   = 0;

    qrs_refine_sequencer #(.DECIM(8), .QWIN_LEN(32), .SWIN_LEN(48)) dut (
        .clk           (clk),
        .nReset        (nReset),
        .sample_valid  (sample_valid),
        .r_peak        (r_peak),
        .abort         (abort),
        .clr_ovr       (clr_ovr),
        .count1        (count1),
        .count2        (count2),
        .qwindow1_full (qwindow1_full),
        .swindow1_full (swindow1_full),
        .refine_strobe (refine_strobe),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Apply inputs for one clock, then sample just after the rising edge.
    task automatic cyc(input logic sv, input logic rp, input logic ab, input logic co);
        sample_valid = sv;
        r_peak       = rp;
        abort        = ab;
        clr_ovr      = co;
        @(posedge clk);
        #1;
    endtask

    // Deliver n samples, each preceded by gap idle clocks.
    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_counts(input string tag, input int c1, input int c2);
        check({tag, "_c1"}, 32'(count1), c1);
        check({tag, "_c2"}, 32'(count2), c2);
    endtask

    // From QFILL with `pre` samples already taken, run the beat up to the done cycle.
    task automatic do_beat(input string tag, input int pre, input int gap);
        feed(255 - pre, gap);
        check_counts({tag, "_q255"}, 7, 31);
        check({tag, "_q255_qf"}, 32'(qwindow1_full), 0);
        feed(1, gap);
        check({tag, "_q256_qf"}, 32'(qwindow1_full), 1);
        check({tag, "_q256_sf"}, 32'(swindow1_full), 0);
        check_counts({tag, "_q256"}, 0, 0);
        feed(383, gap);
        check_counts({tag, "_s383"}, 7, 47);
        check({tag, "_s383_sf"}, 32'(swindow1_full), 0);
        feed(1, gap);
        check({tag, "_s384_sf"}, 32'(swindow1_full), 1);
        check({tag, "_s384_qf"}, 32'(qwindow1_full), 1);
        check_counts({tag, "_s384"}, 0, 0);
        feed(9, gap);
        check_counts({tag, "_a9"}, 1, 1);
        check({tag, "_a9_strobe"}, 32'(refine_strobe), 0);
        feed(1, gap);
        check_counts({tag, "_a10"}, 2, 1);
        check({tag, "_a10_strobe"}, 32'(refine_strobe), 1);
        check({tag, "_a10_done"}, 32'(done), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_post_strobe"}, 32'(refine_strobe), 0);
        check({tag, "_post_busy"}, 32'(busy), 0);
        check({tag, "_post_flags"}, 32'({qwindow1_full, swindow1_full}), 0);
        check_counts({tag, "_post"}, 0, 0);
    endtask

    initial begin
        // Power-on reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", 32'({count1, count2, qwindow1_full, swindow1_full,
                               refine_strobe, busy, done, overrun}), 0);
        @(negedge clk);
        nReset = 1'b1;

        // 1. Asynchronous reset in the middle of QFILL.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        feed(20, 0);
        check_counts("t1_pre", 4, 2);
        #2 nReset = 1'b0;
        #1;
        check("t1_async_outs", 32'({count1, count2, qwindow1_full, swindow1_full,
                                    refine_strobe, busy, done, overrun}), 0);
        @(negedge clk);
        nReset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_idle_busy", 32'(busy), 0);
        check_counts("t1_idle", 0, 0);

        // 2. Continuous samples.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_start_busy", 32'(busy), 1);
        check_counts("t2_start", 0, 0);
        do_beat("t2", 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_done_fall", 32'(done), 0);

        // 3. One sample every third clock; counters hold in the gaps.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        feed(5, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_counts("t3_hold1", 5, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_counts("t3_hold2", 5, 0);
        do_beat("t3", 5, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // 4. R-peak during SFILL, overrun clear, set-wins-over-clear.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        feed(256, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_ovr_set", 32'(overrun), 1);
        check_counts("t4_after_rpeak", 1, 0);
        check("t4_qf", 32'(qwindow1_full), 1);
        feed(383, 0);
        check("t4_sf", 32'(swindow1_full), 1);
        check_counts("t4_sfull", 0, 0);
        feed(10, 0);
        check("t4_strobe", 32'(refine_strobe), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_done", 32'(done), 1);
        check("t4_ovr_sticky", 32'(overrun), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_ovr_clr", 32'(overrun), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_idle_rpeak_ovr", 32'(overrun), 0);
        check("t4_busy", 32'(busy), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("t4_set_wins", 32'(overrun), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_abort_busy", 32'(busy), 0);
        check("t4_ovr_after_abort", 32'(overrun), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // 5. Abort in ALIGN at (1,1).
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        feed(256, 0);
        feed(384, 0);
        feed(9, 0);
        check_counts("t5_pre", 1, 1);
        check("t5_pre_busy", 32'(busy), 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check_counts("t5_abort", 0, 0);
        check("t5_flags", 32'({qwindow1_full, swindow1_full}), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_strobe", 32'(refine_strobe), 0);
        check("t5_done", 32'(done), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_done_later", 32'(done), 0);
        check("t5_strobe_later", 32'(refine_strobe), 0);

        // 6. Abort beats r_peak in IDLE; r_peak in the done cycle starts a new beat.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("t6_abort_rpeak_busy", 32'(busy), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        do_beat("t6", 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_new_busy", 32'(busy), 1);
        check("t6_new_done", 32'(done), 0);
        check("t6_new_ovr", 32'(overrun), 0);
        check_counts("t6_new", 0, 0);
        feed(3, 0);
        check_counts("t6_counting", 3, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_end_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
